// File: rtl/tx_self_cal_pkg.sv
// Shared definitions for the TX self-calibration handshake block: sideband
// message codes, initiator/responder state encodings, counter widths and a
// receive-qualification helper.
package tx_self_cal_pkg;

    localparam int unsigned MSG_W = 4;
    localparam int unsigned CAL_W = 8;
    localparam int unsigned TO_W  = 10;

    localparam logic [MSG_W-1:0] MSG_IDLE   = 4'b0000;
    localparam logic [MSG_W-1:0] START_REQ  = 4'b0001;
    localparam logic [MSG_W-1:0] START_RESP = 4'b0010;
    localparam logic [MSG_W-1:0] DONE_REQ   = 4'b0011;
    localparam logic [MSG_W-1:0] DONE_RESP  = 4'b0100;

    typedef logic [2:0] init_state_t;
    localparam init_state_t I_IDLE       = 3'd0;
    localparam init_state_t I_SEND_START = 3'd1;
    localparam init_state_t I_WAIT_START = 3'd2;
    localparam init_state_t I_CAL        = 3'd3;
    localparam init_state_t I_SEND_DONE  = 3'd4;
    localparam init_state_t I_WAIT_DONE  = 3'd5;
    localparam init_state_t I_FINISH     = 3'd6;
    localparam init_state_t I_ERR        = 3'd7;

    typedef logic [2:0] resp_state_t;
    localparam resp_state_t R_IDLE            = 3'd0;
    localparam resp_state_t R_SEND_START_RESP = 3'd1;
    localparam resp_state_t R_WAIT_DONE       = 3'd2;
    localparam resp_state_t R_SEND_DONE_RESP  = 3'd3;
    localparam resp_state_t R_FINISH          = 3'd4;

    // A received code only counts while it is qualified and the block is enabled.
    function automatic logic rx_is(input logic vld, input logic en,
                                   input logic [MSG_W-1:0] msg,
                                   input logic [MSG_W-1:0] code);
        return vld && en && (msg == code);
    endfunction

endpackage

// File: rtl/tx_self_cal_timer.sv
// Load / decrement / expire counter.
// Ports: clk, rst_n (sync, active-low), i_clear (force zero), i_load +
// i_load_val (preset), i_dec (count down, saturating at zero),
// o_expire_c (combinational, high while the count equals one).
module tx_self_cal_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clear,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_expire_c
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Clear dominates load, load dominates decrement.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_load) begin
            cnt_d = i_load_val;
        end else if (i_dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expiring on one lets the owning state last exactly the loaded count.
    assign o_expire_c = (cnt_q == W'(1));

endmodule

// File: rtl/tx_self_cal.sv
// TX self-calibration sideband handshake: an initiator FSM (START_REQ ->
// local calibration -> DONE_REQ) and a responder FSM (answers partner
// requests) share one sideband launch path guarded by a launch token.
// Ports: clk, rst_n (sync, active-low), i_en (enable, low forces idle),
// i_decoded_sideband_message/i_sideband_valid (received code),
// i_busy/i_falling_edge_busy (transmitter status), o_sideband_message/o_valid
// (launch), o_test_ack (both sequences done), o_timeout (wait-state timeout).
// Optional feature macro TX_SELF_CAL_TIMEOUT_EN: bounded wait states and I_ERR.
module tx_self_cal
    import tx_self_cal_pkg::*;
#(
    parameter int unsigned CAL_CYCLES     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic [MSG_W-1:0] i_decoded_sideband_message,
    input  logic             i_sideband_valid,
    input  logic             i_busy,
    input  logic             i_falling_edge_busy,
    output logic [MSG_W-1:0] o_sideband_message,
    output logic             o_valid,
    output logic             o_test_ack,
    output logic             o_timeout
);

    if ((CAL_CYCLES < 1) || (CAL_CYCLES > 255)) begin : g_bad_cal
        $error("CAL_CYCLES must be in 1..255");
    end
    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > ((1 << TO_W) - 1))) begin : g_bad_to
        $error("TIMEOUT_CYCLES must fit the timeout counter");
    end

    init_state_t      init_q, init_d;
    resp_state_t      resp_q, resp_d;
    logic             token_q, token_d;
    logic [MSG_W-1:0] msg_q, msg_d;
    logic             valid_q, valid_d;
    logic             ack_q, ack_d;

    logic rx_start_req, rx_start_resp, rx_done_req, rx_done_resp;
    logic resp_pend, init_pend, can_launch, resp_launch, init_launch;
    logic cal_load, cal_last;

`ifdef TX_SELF_CAL_TIMEOUT_EN
    logic in_wait, to_expire;
    logic timeout_q, timeout_d;
`endif

    assign rx_start_req  = rx_is(i_sideband_valid, i_en, i_decoded_sideband_message, START_REQ);
    assign rx_start_resp = rx_is(i_sideband_valid, i_en, i_decoded_sideband_message, START_RESP);
    assign rx_done_req   = rx_is(i_sideband_valid, i_en, i_decoded_sideband_message, DONE_REQ);
    assign rx_done_resp  = rx_is(i_sideband_valid, i_en, i_decoded_sideband_message, DONE_RESP);

    // Single launch path: responder has priority, one launch per cycle.
    assign resp_pend   = (resp_q == R_SEND_START_RESP) || (resp_q == R_SEND_DONE_RESP);
    assign init_pend   = (init_q == I_SEND_START) || (init_q == I_SEND_DONE);
    assign can_launch  = i_en && !i_busy && token_q;
    assign resp_launch = can_launch && resp_pend;
    assign init_launch = can_launch && init_pend && !resp_pend;

    // Calibration window counter, loaded on I_WAIT_START -> I_CAL.
    assign cal_load = (init_q == I_WAIT_START) && rx_start_resp;

    tx_self_cal_timer #(.W(CAL_W)) u_cal_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (!i_en),
        .i_load     (cal_load),
        .i_load_val (CAL_W'(CAL_CYCLES)),
        .i_dec      (init_q == I_CAL),
        .o_expire_c (cal_last)
    );

`ifdef TX_SELF_CAL_TIMEOUT_EN
    // Every wait state is entered on an initiator launch, so that is the load point.
    assign in_wait = (init_q == I_WAIT_START) || (init_q == I_WAIT_DONE);

    tx_self_cal_timer #(.W(TO_W)) u_to_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (!i_en || (!init_launch && !in_wait)),
        .i_load     (init_launch),
        .i_load_val (TO_W'(TIMEOUT_CYCLES)),
        .i_dec      (in_wait),
        .o_expire_c (to_expire)
    );
`endif

    // Next-state and registered-output logic for both FSMs.
    always_comb begin
        init_d  = init_q;
        resp_d  = resp_q;
        token_d = token_q;
        msg_d   = MSG_IDLE;
        valid_d = 1'b0;
        ack_d   = 1'b0;

        case (init_q)
            I_IDLE:       init_d = I_SEND_START;
            I_SEND_START: if (init_launch) init_d = I_WAIT_START;
            I_WAIT_START: begin
                if (rx_start_resp) init_d = I_CAL;
`ifdef TX_SELF_CAL_TIMEOUT_EN
                else if (to_expire) init_d = I_ERR;
`endif
            end
            I_CAL:        if (cal_last) init_d = I_SEND_DONE;
            I_SEND_DONE:  if (init_launch) init_d = I_WAIT_DONE;
            I_WAIT_DONE: begin
                if (rx_done_resp) init_d = I_FINISH;
`ifdef TX_SELF_CAL_TIMEOUT_EN
                else if (to_expire) init_d = I_ERR;
`endif
            end
            I_FINISH, I_ERR: init_d = init_q;
            default:      init_d = I_IDLE;
        endcase

        case (resp_q)
            R_IDLE:            if (rx_start_req) resp_d = R_SEND_START_RESP;
            R_SEND_START_RESP: if (resp_launch) resp_d = R_WAIT_DONE;
            R_WAIT_DONE:       if (rx_done_req) resp_d = R_SEND_DONE_RESP;
            R_SEND_DONE_RESP:  if (resp_launch) resp_d = R_FINISH;
            R_FINISH:          resp_d = resp_q;
            default:           resp_d = R_IDLE;
        endcase

        if (resp_launch) begin
            valid_d = 1'b1;
            msg_d   = (resp_q == R_SEND_START_RESP) ? START_RESP : DONE_RESP;
        end else if (init_launch) begin
            valid_d = 1'b1;
            msg_d   = (init_q == I_SEND_START) ? START_REQ : DONE_REQ;
        end

        // A launch in the same cycle as a busy falling edge leaves the token cleared.
        if (resp_launch || init_launch) begin
            token_d = 1'b0;
        end else if (i_falling_edge_busy) begin
            token_d = 1'b1;
        end

        ack_d = (init_q == I_FINISH) && (resp_q == R_FINISH);

        if (!i_en) begin
            init_d  = I_IDLE;
            resp_d  = R_IDLE;
            token_d = 1'b1;
            msg_d   = MSG_IDLE;
            valid_d = 1'b0;
            ack_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            init_q  <= I_IDLE;
            resp_q  <= R_IDLE;
            token_q <= 1'b1;
            msg_q   <= MSG_IDLE;
            valid_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            init_q  <= init_d;
            resp_q  <= resp_d;
            token_q <= token_d;
            msg_q   <= msg_d;
            valid_q <= valid_d;
            ack_q   <= ack_d;
        end
    end

    assign o_sideband_message = msg_q;
    assign o_valid            = valid_q;
    assign o_test_ack         = ack_q;

`ifdef TX_SELF_CAL_TIMEOUT_EN
    assign timeout_d = (init_d == I_ERR);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end

    assign o_timeout = timeout_q;
`else
    assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_tx_self_cal.sv
// Self-checking bench for tx_self_cal. The bench plays the sideband partner
// and a transmitter that stays busy for bl cycles after each launch and then
// pulses i_falling_edge_busy. Expected launch cycles come from the protocol
// rules: a launch becomes visible one cycle after its SEND state is entered,
// and no earlier than bl+2 cycles after the previous launch.
module tb_tx_self_cal;

    localparam int unsigned CAL = 16;
    localparam int unsigned TO  = 8;

    localparam logic [3:0] C_IDLE       = 4'b0000;
    localparam logic [3:0] C_START_REQ  = 4'b0001;
    localparam logic [3:0] C_START_RESP = 4'b0010;
    localparam logic [3:0] C_DONE_REQ   = 4'b0011;
    localparam logic [3:0] C_DONE_RESP  = 4'b0100;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_en;
    logic [3:0] i_decoded_sideband_message;
    logic       i_sideband_valid;
    logic       i_busy;
    logic       i_falling_edge_busy;
    logic [3:0] o_sideband_message;
    logic       o_valid;
    logic       o_test_ack;
    logic       o_timeout;

    always #5 clk = ~clk;

    tx_self_cal #(.CAL_CYCLES(CAL), .TIMEOUT_CYCLES(TO)) dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .i_en                       (i_en),
        .i_decoded_sideband_message (i_decoded_sideband_message),
        .i_sideband_valid           (i_sideband_valid),
        .i_busy                     (i_busy),
        .i_falling_edge_busy        (i_falling_edge_busy),
        .o_sideband_message         (o_sideband_message),
        .o_valid                    (o_valid),
        .o_test_ack                 (o_test_ack),
        .o_timeout                  (o_timeout)
    );

    int         n_check = 0;
    int         n_pass  = 0;
    int         cyc     = 0;
    int         n_launch = 0;
    bit         tx_auto;
    int         bl;
    int         busy_left;
    bit         fall_pending;
    bit         last_valid;
    logic [3:0] last_code;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One clock: drive transmitter model, step, sample outputs, update model.
    task automatic tick();
        if (tx_auto) begin
            i_busy              = (busy_left > 0);
            i_falling_edge_busy = (busy_left == 0) && fall_pending;
        end
        @(posedge clk);
        #1;
        cyc++;
        i_sideband_valid           = 1'b0;
        i_decoded_sideband_message = C_IDLE;
        if (tx_auto) begin
            if (busy_left > 0) begin
                busy_left--;
                fall_pending = (busy_left == 0);
            end else begin
                fall_pending = 1'b0;
            end
        end
        last_valid = o_valid;
        last_code  = o_sideband_message;
        if (o_valid) begin
            n_launch++;
            if (tx_auto) begin
                busy_left    = bl;
                fall_pending = 1'b0;
            end
        end
    endtask

    task automatic send_rx(input logic [3:0] code);
        i_sideband_valid           = 1'b1;
        i_decoded_sideband_message = code;
        tick();
    endtask

    task automatic wait_launch(input int budget, output int at, output logic [3:0] code);
        at   = -1;
        code = C_IDLE;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (last_valid) begin
                at   = cyc;
                code = last_code;
                break;
            end
        end
    endtask

    task automatic quiesce();
        tx_auto = 1'b1;
        i_en    = 1'b0;
        repeat (8) tick();
        busy_left    = 0;
        fall_pending = 1'b0;
        bl = int'($urandom_range(1, 4));
    endtask

    task automatic test_reset();
        int at; int exp; logic [3:0] code;
        rst_n = 1'b0;
        i_en  = 1'b1;
        repeat (3) tick();
        n_check++; if (o_valid !== 1'b0) $display("FAIL reset_valid: got %b, expected 0", o_valid); else n_pass++;
        n_check++; if (o_sideband_message !== C_IDLE) $display("FAIL reset_msg: got %b, expected 0000", o_sideband_message); else n_pass++;
        n_check++; if (o_test_ack !== 1'b0) $display("FAIL reset_ack: got %b, expected 0", o_test_ack); else n_pass++;
        n_check++; if (o_timeout !== 1'b0) $display("FAIL reset_timeout: got %b, expected 0", o_timeout); else n_pass++;
        rst_n = 1'b1;
        tick();
        exp = cyc + 1;
        n_check++; if (o_valid !== 1'b0) $display("FAIL reset_release_valid: got %b, expected 0", o_valid); else n_pass++;
        wait_launch(8, at, code);
        n_check++; if (at !== exp || code !== C_START_REQ) $display("FAIL reset_first_launch: got cyc %0d code %b, expected cyc %0d code %b", at, code, exp, C_START_REQ); else n_pass++;
        quiesce();
    endtask

    task automatic test_ideal(input int iter);
        int at; int exp; int tok; int d; int r; int n0; logic [3:0] code;
        n0 = n_launch;
        i_en = 1'b1;
        tick();
        exp = cyc + 1;
        wait_launch(8, at, code);
        n_check++; if (at !== exp || code !== C_START_REQ) $display("FAIL ideal%0d_start_req: got cyc %0d code %b, expected cyc %0d code %b", iter, at, code, exp, C_START_REQ); else n_pass++;
        tok = exp + bl + 2;
        d = int'($urandom_range(2, 8));
        send_rx(C_DONE_RESP);                  // wrong phase, must be ignored
        repeat (d - 2) tick();
        send_rx(C_START_RESP);
        r = cyc;
        exp = max2(r + CAL + 1, tok);
        wait_launch(CAL + 12, at, code);
        n_check++; if (at !== exp || code !== C_DONE_REQ) $display("FAIL ideal%0d_done_req: got cyc %0d code %b, expected cyc %0d code %b", iter, at, code, exp, C_DONE_REQ); else n_pass++;
        tok = exp + bl + 2;
        d = int'($urandom_range(2, 8));
        repeat (d - 1) tick();
        send_rx(C_DONE_RESP);
        repeat (3) tick();
        n_check++; if (o_test_ack !== 1'b0) $display("FAIL ideal%0d_ack_initiator_only: got %b, expected 0", iter, o_test_ack); else n_pass++;
        send_rx(C_DONE_REQ);                   // responder still idle, must be ignored
        send_rx(C_START_REQ);
        exp = max2(cyc + 1, tok);
        wait_launch(12, at, code);
        n_check++; if (at !== exp || code !== C_START_RESP) $display("FAIL ideal%0d_start_resp: got cyc %0d code %b, expected cyc %0d code %b", iter, at, code, exp, C_START_RESP); else n_pass++;
        tok = exp + bl + 2;
        d = int'($urandom_range(1, 8));
        repeat (d - 1) tick();
        send_rx(C_DONE_REQ);
        exp = max2(cyc + 1, tok);
        wait_launch(12, at, code);
        n_check++; if (at !== exp || code !== C_DONE_RESP) $display("FAIL ideal%0d_done_resp: got cyc %0d code %b, expected cyc %0d code %b", iter, at, code, exp, C_DONE_RESP); else n_pass++;
        n_check++; if (o_test_ack !== 1'b0) $display("FAIL ideal%0d_ack_early: got %b, expected 0", iter, o_test_ack); else n_pass++;
        tick();
        n_check++; if (o_test_ack !== 1'b1) $display("FAIL ideal%0d_ack: got %b, expected 1", iter, o_test_ack); else n_pass++;
        n_check++; if (n_launch - n0 != 4) $display("FAIL ideal%0d_launch_count: got %0d, expected 4", iter, n_launch - n0); else n_pass++;
        i_en = 1'b0;
        tick();
        n_check++;
        if (o_test_ack !== 1'b0 || o_valid !== 1'b0 || o_sideband_message !== C_IDLE || o_timeout !== 1'b0)
            $display("FAIL ideal%0d_disable: got ack %b valid %b msg %b timeout %b, expected all 0", iter, o_test_ack, o_valid, o_sideband_message, o_timeout);
        else n_pass++;
        quiesce();
    endtask

    task automatic test_collision();
        int at; int exp; logic [3:0] code;
        i_en                       = 1'b1;
        i_sideband_valid           = 1'b1;
        i_decoded_sideband_message = C_START_REQ;
        tick();
        exp = cyc + 1;
        wait_launch(8, at, code);
        n_check++; if (at !== exp || code !== C_START_RESP) $display("FAIL collision_resp_first: got cyc %0d code %b, expected cyc %0d code %b", at, code, exp, C_START_RESP); else n_pass++;
        exp = exp + bl + 2;
        wait_launch(12, at, code);
        n_check++; if (at !== exp || code !== C_START_REQ) $display("FAIL collision_req_second: got cyc %0d code %b, expected cyc %0d code %b", at, code, exp, C_START_REQ); else n_pass++;
        quiesce();
    endtask

    task automatic test_busy();
        int n0;
        tx_auto             = 1'b0;
        i_busy              = 1'b1;
        i_falling_edge_busy = 1'b0;
        i_en                = 1'b1;
        n0 = n_launch;
        repeat (20) tick();
        n_check++; if (n_launch != n0) $display("FAIL busy_hold: got %0d launches, expected 0", n_launch - n0); else n_pass++;
        i_busy              = 1'b0;
        i_falling_edge_busy = 1'b1;            // coincides with the launch
        tick();
        i_falling_edge_busy = 1'b0;
        n_check++; if (last_valid !== 1'b1 || last_code !== C_START_REQ) $display("FAIL busy_release_launch: got valid %b code %b, expected 1 %b", last_valid, last_code, C_START_REQ); else n_pass++;
        repeat (2) tick();
        send_rx(C_START_REQ);
        repeat (10) tick();
        n_check++; if (n_launch - n0 != 1) $display("FAIL busy_token_cleared: got %0d launches, expected 1", n_launch - n0); else n_pass++;
        i_falling_edge_busy = 1'b1;
        tick();
        i_falling_edge_busy = 1'b0;
        n_check++; if (last_valid !== 1'b0) $display("FAIL busy_token_edge: got valid %b, expected 0", last_valid); else n_pass++;
        tick();
        n_check++; if (last_valid !== 1'b1 || last_code !== C_START_RESP) $display("FAIL busy_token_launch: got valid %b code %b, expected 1 %b", last_valid, last_code, C_START_RESP); else n_pass++;
        quiesce();
    endtask

    task automatic test_reset_cal();
        int at; int exp; int s; logic [3:0] code;
        i_en = 1'b1;
        tick();
        exp = cyc + 1;
        wait_launch(8, at, code);
        n_check++; if (at !== exp || code !== C_START_REQ) $display("FAIL rstcal_start_req: got cyc %0d code %b, expected cyc %0d code %b", at, code, exp, C_START_REQ); else n_pass++;
        repeat (2) tick();
        send_rx(C_START_RESP);
        repeat (3) tick();
        send_rx(C_START_REQ);                  // START_RESP would launch next cycle
        s = cyc;
        rst_n = 1'b0;
        tick();
        n_check++;
        if (o_valid !== 1'b0 || o_sideband_message !== C_IDLE || o_test_ack !== 1'b0 || o_timeout !== 1'b0)
            $display("FAIL rstcal_outputs: got valid %b msg %b ack %b timeout %b, expected all 0", o_valid, o_sideband_message, o_test_ack, o_timeout);
        else n_pass++;
        rst_n = 1'b1;
        tick();
        n_check++; if (o_valid !== 1'b0) $display("FAIL rstcal_release_valid: got %b, expected 0", o_valid); else n_pass++;
        exp = s + 3;
        wait_launch(8, at, code);
        n_check++; if (at !== exp || code !== C_START_REQ) $display("FAIL rstcal_restart: got cyc %0d code %b, expected cyc %0d code %b", at, code, exp, C_START_REQ); else n_pass++;
        quiesce();
    endtask

    task automatic test_timeout();
        int at; int exp; int l1; int r; bit bad; logic [3:0] code;
        i_en = 1'b1;
        tick();
        l1 = cyc + 1;
        wait_launch(8, at, code);
        n_check++; if (at !== l1 || code !== C_START_REQ) $display("FAIL to_start_req: got cyc %0d code %b, expected cyc %0d code %b", at, code, l1, C_START_REQ); else n_pass++;
`ifdef TX_SELF_CAL_TIMEOUT_EN
        while (cyc < l1 + int'(TO) - 1) tick();
        n_check++; if (o_timeout !== 1'b0) $display("FAIL to_before_limit: got %b, expected 0", o_timeout); else n_pass++;
        tick();
        n_check++; if (o_timeout !== 1'b1) $display("FAIL to_at_limit: got %b, expected 1", o_timeout); else n_pass++;
        bad = 1'b0;
        send_rx(C_START_RESP);                 // too late, error state ignores it
        repeat (CAL + 4) begin
            tick();
            if (o_test_ack !== 1'b0 || o_timeout !== 1'b1 || o_valid !== 1'b0) bad = 1'b1;
        end
        n_check++; if (bad) $display("FAIL to_hold: got ack %b timeout %b valid %b, expected 0 1 0 throughout", o_test_ack, o_timeout, o_valid); else n_pass++;
        i_en = 1'b0;
        tick();
        n_check++; if (o_timeout !== 1'b0) $display("FAIL to_clear: got %b, expected 0", o_timeout); else n_pass++;
        r = 0;
        exp = 0;
`else
        bad = 1'b0;
        repeat (40) begin
            tick();
            if (o_timeout !== 1'b0) bad = 1'b1;
        end
        n_check++; if (bad) $display("FAIL to_unbounded: got timeout %b, expected 0 throughout", o_timeout); else n_pass++;
        send_rx(C_START_RESP);
        r = cyc;
        exp = max2(r + CAL + 1, l1 + bl + 2);
        wait_launch(CAL + 12, at, code);
        n_check++; if (at !== exp || code !== C_DONE_REQ) $display("FAIL to_late_resp: got cyc %0d code %b, expected cyc %0d code %b", at, code, exp, C_DONE_REQ); else n_pass++;
`endif
        quiesce();
    endtask

    initial begin
        rst_n                      = 1'b0;
        i_en                       = 1'b0;
        i_decoded_sideband_message = C_IDLE;
        i_sideband_valid           = 1'b0;
        i_busy                     = 1'b0;
        i_falling_edge_busy        = 1'b0;
        tx_auto                    = 1'b1;
        bl                         = 2;
        busy_left                  = 0;
        fall_pending               = 1'b0;
        test_reset();
        for (int k = 0; k < 3; k++) begin
            bl = int'($urandom_range(1, 4));
            test_ideal(k);
        end
        test_collision();
        test_busy();
        test_reset_cal();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_check);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not complete, %0d of %0d checks passed so far", n_pass, n_check);
        $fatal(1, "watchdog expired");
    end

endmodule
